// File: rtl/mqs_axi4_pkg.sv
// Shared types for the AXI4 outstanding-transaction limiter: quiesce FSM
// states and the width of the outstanding counters.
package mqs_axi4_pkg;

    localparam int OT_CNT_WIDTH = 8;

    typedef logic [OT_CNT_WIDTH-1:0] ot_cnt_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_QUIESCED = 2'd2
    } ot_state_e;

    function automatic ot_cnt_t ot_limit(input int max_ot);
        return ot_cnt_t'(max_ot);
    endfunction

endpackage

// File: rtl/mqs_ot_counter.sv
// Outstanding-transaction counter: up on issue, down on completion,
// simultaneous inc/dec cancel, sticky underflow flag on a decrement at zero.
module mqs_ot_counter
    import mqs_axi4_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    inc,
    input  logic    dec,
    input  ot_cnt_t max,
    output ot_cnt_t count,
    output logic    at_max,
    output logic    underflow
);

    ot_cnt_t count_reg;
    ot_cnt_t count_next;
    logic    underflow_reg;
    logic    underflow_next;

    always_comb begin
        count_next     = count_reg;
        underflow_next = underflow_reg;
        if (inc && !dec) begin
            // The issue-side gate keeps us below max; the check is a backstop only.
            if (count_reg < max) count_next = count_reg + ot_cnt_t'(1);
        end else if (dec && !inc) begin
            if (count_reg == '0) underflow_next = 1'b1;
            else                 count_next     = count_reg - ot_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            underflow_reg <= underflow_next;
        end
    end

    assign count     = count_reg;
    assign at_max    = (count_reg >= max);
    assign underflow = underflow_reg;

endmodule

// File: rtl/mqs_axi4_ot_limiter.sv
// AXI4 pass-through that caps outstanding writes/reads and can drain to a
// quiesced state; all payloads and the W/B/R channels are combinational.
module mqs_axi4_ot_limiter
    import mqs_axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 1,
    parameter int MAX_WR_OT  = 8,
    parameter int MAX_RD_OT  = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    // upstream AW
    input  logic [ID_WIDTH-1:0]     mst_AWID,
    input  logic [ADDR_WIDTH-1:0]   mst_AWADDR,
    input  logic [7:0]              mst_AWLEN,
    input  logic [2:0]              mst_AWSIZE,
    input  logic [1:0]              mst_AWBURST,
    input  logic                    mst_AWLOCK,
    input  logic [3:0]              mst_AWCACHE,
    input  logic [2:0]              mst_AWPROT,
    input  logic [3:0]              mst_AWQOS,
    input  logic [3:0]              mst_AWREGION,
    input  logic [USER_WIDTH-1:0]   mst_AWUSER,
    input  logic                    mst_AWVALID,
    output logic                    mst_AWREADY,
    // upstream W
    input  logic [DATA_WIDTH-1:0]   mst_WDATA,
    input  logic [DATA_WIDTH/8-1:0] mst_WSTRB,
    input  logic                    mst_WLAST,
    input  logic [USER_WIDTH-1:0]   mst_WUSER,
    input  logic                    mst_WVALID,
    output logic                    mst_WREADY,
    // upstream B
    output logic [ID_WIDTH-1:0]     mst_BID,
    output logic [1:0]              mst_BRESP,
    output logic [USER_WIDTH-1:0]   mst_BUSER,
    output logic                    mst_BVALID,
    input  logic                    mst_BREADY,
    // upstream AR
    input  logic [ID_WIDTH-1:0]     mst_ARID,
    input  logic [ADDR_WIDTH-1:0]   mst_ARADDR,
    input  logic [7:0]              mst_ARLEN,
    input  logic [2:0]              mst_ARSIZE,
    input  logic [1:0]              mst_ARBURST,
    input  logic                    mst_ARLOCK,
    input  logic [3:0]              mst_ARCACHE,
    input  logic [2:0]              mst_ARPROT,
    input  logic [3:0]              mst_ARQOS,
    input  logic [3:0]              mst_ARREGION,
    input  logic [USER_WIDTH-1:0]   mst_ARUSER,
    input  logic                    mst_ARVALID,
    output logic                    mst_ARREADY,
    // upstream R
    output logic [ID_WIDTH-1:0]     mst_RID,
    output logic [DATA_WIDTH-1:0]   mst_RDATA,
    output logic [1:0]              mst_RRESP,
    output logic                    mst_RLAST,
    output logic [USER_WIDTH-1:0]   mst_RUSER,
    output logic                    mst_RVALID,
    input  logic                    mst_RREADY,
    // downstream AW
    output logic [ID_WIDTH-1:0]     slv_AWID,
    output logic [ADDR_WIDTH-1:0]   slv_AWADDR,
    output logic [7:0]              slv_AWLEN,
    output logic [2:0]              slv_AWSIZE,
    output logic [1:0]              slv_AWBURST,
    output logic                    slv_AWLOCK,
    output logic [3:0]              slv_AWCACHE,
    output logic [2:0]              slv_AWPROT,
    output logic [3:0]              slv_AWQOS,
    output logic [3:0]              slv_AWREGION,
    output logic [USER_WIDTH-1:0]   slv_AWUSER,
    output logic                    slv_AWVALID,
    input  logic                    slv_AWREADY,
    // downstream W
    output logic [DATA_WIDTH-1:0]   slv_WDATA,
    output logic [DATA_WIDTH/8-1:0] slv_WSTRB,
    output logic                    slv_WLAST,
    output logic [USER_WIDTH-1:0]   slv_WUSER,
    output logic                    slv_WVALID,
    input  logic                    slv_WREADY,
    // downstream B
    input  logic [ID_WIDTH-1:0]     slv_BID,
    input  logic [1:0]              slv_BRESP,
    input  logic [USER_WIDTH-1:0]   slv_BUSER,
    input  logic                    slv_BVALID,
    output logic                    slv_BREADY,
    // downstream AR
    output logic [ID_WIDTH-1:0]     slv_ARID,
    output logic [ADDR_WIDTH-1:0]   slv_ARADDR,
    output logic [7:0]              slv_ARLEN,
    output logic [2:0]              slv_ARSIZE,
    output logic [1:0]              slv_ARBURST,
    output logic                    slv_ARLOCK,
    output logic [3:0]              slv_ARCACHE,
    output logic [2:0]              slv_ARPROT,
    output logic [3:0]              slv_ARQOS,
    output logic [3:0]              slv_ARREGION,
    output logic [USER_WIDTH-1:0]   slv_ARUSER,
    output logic                    slv_ARVALID,
    input  logic                    slv_ARREADY,
    // downstream R
    input  logic [ID_WIDTH-1:0]     slv_RID,
    input  logic [DATA_WIDTH-1:0]   slv_RDATA,
    input  logic [1:0]              slv_RRESP,
    input  logic                    slv_RLAST,
    input  logic [USER_WIDTH-1:0]   slv_RUSER,
    input  logic                    slv_RVALID,
    output logic                    slv_RREADY,
    // control / status
    input  logic                    quiesce_req,
    output logic                    quiesce_ack,
    output logic [7:0]              wr_ot_cnt,
    output logic [7:0]              rd_ot_cnt,
    output logic [1:0]              err_underflow
);

    ot_state_e state_reg;
    ot_state_e state_next;
    logic      quiesce_ack_reg;
    logic      aw_held_reg;
    logic      aw_held_next;
    logic      ar_held_reg;
    logic      ar_held_next;
    logic      aw_allow;
    logic      ar_allow;
    logic      drained;

    // Index 0 tracks writes, index 1 tracks reads.
    logic [1:0] ot_inc;
    logic [1:0] ot_dec;
    logic [1:0] ot_at_max;
    logic [1:0] ot_underflow;
    ot_cnt_t    ot_count [2];
    ot_cnt_t    ot_max_val [2];

    assign slv_AWID     = mst_AWID;
    assign slv_AWADDR   = mst_AWADDR;
    assign slv_AWLEN    = mst_AWLEN;
    assign slv_AWSIZE   = mst_AWSIZE;
    assign slv_AWBURST  = mst_AWBURST;
    assign slv_AWLOCK   = mst_AWLOCK;
    assign slv_AWCACHE  = mst_AWCACHE;
    assign slv_AWPROT   = mst_AWPROT;
    assign slv_AWQOS    = mst_AWQOS;
    assign slv_AWREGION = mst_AWREGION;
    assign slv_AWUSER   = mst_AWUSER;

    assign slv_ARID     = mst_ARID;
    assign slv_ARADDR   = mst_ARADDR;
    assign slv_ARLEN    = mst_ARLEN;
    assign slv_ARSIZE   = mst_ARSIZE;
    assign slv_ARBURST  = mst_ARBURST;
    assign slv_ARLOCK   = mst_ARLOCK;
    assign slv_ARCACHE  = mst_ARCACHE;
    assign slv_ARPROT   = mst_ARPROT;
    assign slv_ARQOS    = mst_ARQOS;
    assign slv_ARREGION = mst_ARREGION;
    assign slv_ARUSER   = mst_ARUSER;

    assign slv_WDATA    = mst_WDATA;
    assign slv_WSTRB    = mst_WSTRB;
    assign slv_WLAST    = mst_WLAST;
    assign slv_WUSER    = mst_WUSER;
    assign slv_WVALID   = mst_WVALID;
    assign mst_WREADY   = slv_WREADY;

    assign mst_BID      = slv_BID;
    assign mst_BRESP    = slv_BRESP;
    assign mst_BUSER    = slv_BUSER;
    assign mst_BVALID   = slv_BVALID;
    assign slv_BREADY   = mst_BREADY;

    assign mst_RID      = slv_RID;
    assign mst_RDATA    = slv_RDATA;
    assign mst_RRESP    = slv_RRESP;
    assign mst_RLAST    = slv_RLAST;
    assign mst_RUSER    = slv_RUSER;
    assign mst_RVALID   = slv_RVALID;
    assign slv_RREADY   = mst_RREADY;

    // A request already presented downstream stays allowed until it handshakes.
    assign aw_allow    = aw_held_reg | (!ot_at_max[0] && state_reg == ST_RUN);
    assign ar_allow    = ar_held_reg | (!ot_at_max[1] && state_reg == ST_RUN);
    assign slv_AWVALID = mst_AWVALID & aw_allow;
    assign mst_AWREADY = slv_AWREADY & aw_allow;
    assign slv_ARVALID = mst_ARVALID & ar_allow;
    assign mst_ARREADY = slv_ARREADY & ar_allow;

    assign aw_held_next = slv_AWVALID ? !slv_AWREADY : aw_held_reg;
    assign ar_held_next = slv_ARVALID ? !slv_ARREADY : ar_held_reg;

    assign ot_inc[0]     = slv_AWVALID & slv_AWREADY;
    assign ot_dec[0]     = slv_BVALID & mst_BREADY;
    assign ot_inc[1]     = slv_ARVALID & slv_ARREADY;
    assign ot_dec[1]     = slv_RVALID & mst_RREADY & slv_RLAST;
    assign ot_max_val[0] = ot_limit(MAX_WR_OT);
    assign ot_max_val[1] = ot_limit(MAX_RD_OT);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ot
            mqs_ot_counter u_ot_counter (
                .clk       (ACLK),
                .rst_n     (ARESETn),
                .inc       (ot_inc[gi]),
                .dec       (ot_dec[gi]),
                .max       (ot_max_val[gi]),
                .count     (ot_count[gi]),
                .at_max    (ot_at_max[gi]),
                .underflow (ot_underflow[gi])
            );
        end
    endgenerate

    assign drained = (ot_count[0] == '0) && (ot_count[1] == '0) &&
                     !aw_held_reg && !ar_held_reg;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_RUN:      if (quiesce_req) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!quiesce_req) state_next = ST_RUN;
                else if (drained) state_next = ST_QUIESCED;
            end
            ST_QUIESCED: if (!quiesce_req) state_next = ST_RUN;
            default:     state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg       <= ST_RUN;
            quiesce_ack_reg <= 1'b0;
            aw_held_reg     <= 1'b0;
            ar_held_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            quiesce_ack_reg <= (state_next == ST_QUIESCED);
            aw_held_reg     <= aw_held_next;
            ar_held_reg     <= ar_held_next;
        end
    end

    assign quiesce_ack   = quiesce_ack_reg;
    assign wr_ot_cnt     = ot_count[0];
    assign rd_ot_cnt     = ot_count[1];
    assign err_underflow = ot_underflow;

endmodule

// File: tb/tb_mqs_axi4_ot_limiter.sv
// Directed bench for the outstanding-transaction limiter: table of per-cycle
// vectors plus hand-written stall, quiesce and async-reset sequences.
module tb_mqs_axi4_ot_limiter;

    localparam logic [7:0] AWV = 8'h80, AWR = 8'h40, BV = 8'h20, ARV = 8'h10;
    localparam logic [7:0] ARR = 8'h08, RV  = 8'h04, RL = 8'h02, Q  = 8'h01;
    localparam logic [7:0] IDLE = 8'h00;

    logic        ACLK, ARESETn;
    logic [7:0]  mst_AWID, mst_AWLEN, mst_ARID, mst_ARLEN;
    logic [63:0] mst_AWADDR, mst_ARADDR, mst_WDATA;
    logic [2:0]  mst_AWSIZE, mst_AWPROT, mst_ARSIZE, mst_ARPROT;
    logic [1:0]  mst_AWBURST, mst_ARBURST;
    logic [3:0]  mst_AWCACHE, mst_AWQOS, mst_AWREGION, mst_ARCACHE, mst_ARQOS, mst_ARREGION;
    logic        mst_AWLOCK, mst_AWUSER, mst_AWVALID, mst_AWREADY;
    logic        mst_ARLOCK, mst_ARUSER, mst_ARVALID, mst_ARREADY;
    logic [7:0]  mst_WSTRB;
    logic        mst_WLAST, mst_WUSER, mst_WVALID, mst_WREADY;
    logic [7:0]  mst_BID, mst_RID;
    logic [1:0]  mst_BRESP, mst_RRESP;
    logic        mst_BUSER, mst_BVALID, mst_BREADY;
    logic [63:0] mst_RDATA;
    logic        mst_RLAST, mst_RUSER, mst_RVALID, mst_RREADY;
    logic [7:0]  slv_AWID, slv_AWLEN, slv_ARID, slv_ARLEN;
    logic [63:0] slv_AWADDR, slv_ARADDR, slv_WDATA;
    logic [2:0]  slv_AWSIZE, slv_AWPROT, slv_ARSIZE, slv_ARPROT;
    logic [1:0]  slv_AWBURST, slv_ARBURST;
    logic [3:0]  slv_AWCACHE, slv_AWQOS, slv_AWREGION, slv_ARCACHE, slv_ARQOS, slv_ARREGION;
    logic        slv_AWLOCK, slv_AWUSER, slv_AWVALID, slv_AWREADY;
    logic        slv_ARLOCK, slv_ARUSER, slv_ARVALID, slv_ARREADY;
    logic [7:0]  slv_WSTRB;
    logic        slv_WLAST, slv_WUSER, slv_WVALID, slv_WREADY;
    logic [7:0]  slv_BID, slv_RID;
    logic [1:0]  slv_BRESP, slv_RRESP;
    logic        slv_BUSER, slv_BVALID, slv_BREADY;
    logic [63:0] slv_RDATA;
    logic        slv_RLAST, slv_RUSER, slv_RVALID, slv_RREADY;
    logic        quiesce_req, quiesce_ack;
    logic [7:0]  wr_ot_cnt, rd_ot_cnt;
    logic [1:0]  err_underflow;

    mqs_axi4_ot_limiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .mst_AWID(mst_AWID), .mst_AWADDR(mst_AWADDR), .mst_AWLEN(mst_AWLEN), .mst_AWSIZE(mst_AWSIZE),
        .mst_AWBURST(mst_AWBURST), .mst_AWLOCK(mst_AWLOCK), .mst_AWCACHE(mst_AWCACHE), .mst_AWPROT(mst_AWPROT),
        .mst_AWQOS(mst_AWQOS), .mst_AWREGION(mst_AWREGION), .mst_AWUSER(mst_AWUSER),
        .mst_AWVALID(mst_AWVALID), .mst_AWREADY(mst_AWREADY),
        .mst_WDATA(mst_WDATA), .mst_WSTRB(mst_WSTRB), .mst_WLAST(mst_WLAST), .mst_WUSER(mst_WUSER),
        .mst_WVALID(mst_WVALID), .mst_WREADY(mst_WREADY),
        .mst_BID(mst_BID), .mst_BRESP(mst_BRESP), .mst_BUSER(mst_BUSER), .mst_BVALID(mst_BVALID), .mst_BREADY(mst_BREADY),
        .mst_ARID(mst_ARID), .mst_ARADDR(mst_ARADDR), .mst_ARLEN(mst_ARLEN), .mst_ARSIZE(mst_ARSIZE),
        .mst_ARBURST(mst_ARBURST), .mst_ARLOCK(mst_ARLOCK), .mst_ARCACHE(mst_ARCACHE), .mst_ARPROT(mst_ARPROT),
        .mst_ARQOS(mst_ARQOS), .mst_ARREGION(mst_ARREGION), .mst_ARUSER(mst_ARUSER),
        .mst_ARVALID(mst_ARVALID), .mst_ARREADY(mst_ARREADY),
        .mst_RID(mst_RID), .mst_RDATA(mst_RDATA), .mst_RRESP(mst_RRESP), .mst_RLAST(mst_RLAST),
        .mst_RUSER(mst_RUSER), .mst_RVALID(mst_RVALID), .mst_RREADY(mst_RREADY),
        .slv_AWID(slv_AWID), .slv_AWADDR(slv_AWADDR), .slv_AWLEN(slv_AWLEN), .slv_AWSIZE(slv_AWSIZE),
        .slv_AWBURST(slv_AWBURST), .slv_AWLOCK(slv_AWLOCK), .slv_AWCACHE(slv_AWCACHE), .slv_AWPROT(slv_AWPROT),
        .slv_AWQOS(slv_AWQOS), .slv_AWREGION(slv_AWREGION), .slv_AWUSER(slv_AWUSER),
        .slv_AWVALID(slv_AWVALID), .slv_AWREADY(slv_AWREADY),
        .slv_WDATA(slv_WDATA), .slv_WSTRB(slv_WSTRB), .slv_WLAST(slv_WLAST), .slv_WUSER(slv_WUSER),
        .slv_WVALID(slv_WVALID), .slv_WREADY(slv_WREADY),
        .slv_BID(slv_BID), .slv_BRESP(slv_BRESP), .slv_BUSER(slv_BUSER), .slv_BVALID(slv_BVALID), .slv_BREADY(slv_BREADY),
        .slv_ARID(slv_ARID), .slv_ARADDR(slv_ARADDR), .slv_ARLEN(slv_ARLEN), .slv_ARSIZE(slv_ARSIZE),
        .slv_ARBURST(slv_ARBURST), .slv_ARLOCK(slv_ARLOCK), .slv_ARCACHE(slv_ARCACHE), .slv_ARPROT(slv_ARPROT),
        .slv_ARQOS(slv_ARQOS), .slv_ARREGION(slv_ARREGION), .slv_ARUSER(slv_ARUSER),
        .slv_ARVALID(slv_ARVALID), .slv_ARREADY(slv_ARREADY),
        .slv_RID(slv_RID), .slv_RDATA(slv_RDATA), .slv_RRESP(slv_RRESP), .slv_RLAST(slv_RLAST),
        .slv_RUSER(slv_RUSER), .slv_RVALID(slv_RVALID), .slv_RREADY(slv_RREADY),
        .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
        .wr_ot_cnt(wr_ot_cnt), .rd_ot_cnt(rd_ot_cnt), .err_underflow(err_underflow)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        string      name;
        logic [7:0] stim;
        logic       e_awready, e_awvalid, e_arready;
        logic [7:0] e_wr, e_rd;
        logic       e_ack;
        logic [1:0] e_err;
    } vec_t;

    vec_t tbl [30];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input string nm, input logic [7:0] stim, input logic awrdy,
                                input logic awvs, input logic arrdy, input logic [7:0] wr,
                                input logic [7:0] rd, input logic ack, input logic [1:0] err);
        vec_t v;
        v.name = nm; v.stim = stim; v.e_awready = awrdy; v.e_awvalid = awvs; v.e_arready = arrdy;
        v.e_wr = wr; v.e_rd = rd; v.e_ack = ack; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] s);
        mst_AWVALID = s[7]; slv_AWREADY = s[6]; slv_BVALID = s[5]; mst_ARVALID = s[4];
        slv_ARREADY = s[3]; slv_RVALID  = s[2]; slv_RLAST  = s[1]; quiesce_req = s[0];
        #1;
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    initial begin
        mst_AWID = 8'h11; mst_AWADDR = 64'h1234_5678_9abc_def0; mst_AWLEN = 8'd3; mst_AWSIZE = 3'd3;
        mst_AWBURST = 2'd1; mst_AWLOCK = 1'b0; mst_AWCACHE = 4'h3; mst_AWPROT = 3'd0;
        mst_AWQOS = 4'h0; mst_AWREGION = 4'h0; mst_AWUSER = 1'b0;
        mst_ARID = 8'h22; mst_ARADDR = 64'h0000_0000_cafe_0000; mst_ARLEN = 8'd3; mst_ARSIZE = 3'd3;
        mst_ARBURST = 2'd1; mst_ARLOCK = 1'b0; mst_ARCACHE = 4'h3; mst_ARPROT = 3'd0;
        mst_ARQOS = 4'h0; mst_ARREGION = 4'h0; mst_ARUSER = 1'b0;
        mst_WDATA = 64'hdead_beef_0bad_f00d; mst_WSTRB = 8'hff; mst_WLAST = 1'b1; mst_WUSER = 1'b0;
        mst_WVALID = 1'b1; slv_WREADY = 1'b1; mst_BREADY = 1'b1; mst_RREADY = 1'b1;
        slv_BID = 8'h5a; slv_BRESP = 2'b00; slv_BUSER = 1'b0;
        slv_RID = 8'h22; slv_RDATA = 64'h0123_4567_89ab_cdef; slv_RRESP = 2'b00; slv_RUSER = 1'b0;
        ARESETn = 1'b1;
        drive(IDLE);
        ARESETn = 1'b0;
        #2;
        chk("reset_wr", wr_ot_cnt, 0); chk("reset_rd", rd_ot_cnt, 0);
        chk("reset_ack", quiesce_ack, 0); chk("reset_err", err_underflow, 0);
        chk("pass_awaddr", slv_AWADDR, 64'h1234_5678_9abc_def0);
        chk("pass_wdata", slv_WDATA, 64'hdead_beef_0bad_f00d);
        chk("pass_rdata", mst_RDATA, 64'h0123_4567_89ab_cdef);
        chk("pass_bid", mst_BID, 8'h5a);
        tick();
        ARESETn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) tbl[i] = mk("aw_fill", AWV|AWR, 1, 1, 0, 8'(i), 0, 0, 0);
        tbl[8]  = mk("aw_blocked",  AWV|AWR,    0, 0, 0, 8, 0, 0, 2'b00);
        tbl[9]  = mk("b_at_max",    AWV|AWR|BV, 0, 0, 0, 8, 0, 0, 2'b00);
        tbl[10] = mk("aw_ninth",    AWV|AWR,    1, 1, 0, 7, 0, 0, 2'b00);
        tbl[11] = mk("b_drain",     BV,         0, 0, 0, 8, 0, 0, 2'b00);
        tbl[12] = mk("b_drain",     BV,         0, 0, 0, 7, 0, 0, 2'b00);
        tbl[13] = mk("b_drain",     BV,         0, 0, 0, 6, 0, 0, 2'b00);
        tbl[14] = mk("b_drain",     BV,         0, 0, 0, 5, 0, 0, 2'b00);
        tbl[15] = mk("b_drain",     BV,         0, 0, 0, 4, 0, 0, 2'b00);
        tbl[16] = mk("aw_b_same",   AWV|AWR|BV, 1, 1, 0, 3, 0, 0, 2'b00);
        tbl[17] = mk("idle_at3",    IDLE,       0, 0, 0, 3, 0, 0, 2'b00);
        tbl[18] = mk("b_drain",     BV,         0, 0, 0, 3, 0, 0, 2'b00);
        tbl[19] = mk("b_drain",     BV,         0, 0, 0, 2, 0, 0, 2'b00);
        tbl[20] = mk("b_drain",     BV,         0, 0, 0, 1, 0, 0, 2'b00);
        tbl[21] = mk("b_at_zero",   BV,         0, 0, 0, 0, 0, 0, 2'b00);
        tbl[22] = mk("err_set",     IDLE,       0, 0, 0, 0, 0, 0, 2'b01);
        tbl[23] = mk("aw_stall",    AWV,        0, 1, 0, 0, 0, 0, 2'b01);
        tbl[24] = mk("aw_accept",   AWV|AWR,    1, 1, 0, 0, 0, 0, 2'b01);
        tbl[25] = mk("b_one",       BV,         0, 0, 0, 1, 0, 0, 2'b01);
        tbl[26] = mk("ar_one",      ARV|ARR,    0, 0, 1, 0, 0, 0, 2'b01);
        tbl[27] = mk("r_beat",      RV,         0, 0, 0, 0, 1, 0, 2'b01);
        tbl[28] = mk("r_last",      RV|RL,      0, 0, 0, 0, 1, 0, 2'b01);
        tbl[29] = mk("err_sticky",  IDLE,       0, 0, 0, 0, 0, 0, 2'b01);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].stim);
            $display("vec %0d %s: awready=%0d awvalid=%0d arready=%0d wr=%0d rd=%0d ack=%0d err=%0b",
                     i, tbl[i].name, mst_AWREADY, slv_AWVALID, mst_ARREADY, wr_ot_cnt, rd_ot_cnt,
                     quiesce_ack, err_underflow);
            chk({tbl[i].name, "_awready"}, mst_AWREADY, tbl[i].e_awready);
            chk({tbl[i].name, "_awvalid"}, slv_AWVALID, tbl[i].e_awvalid);
            chk({tbl[i].name, "_arready"}, mst_ARREADY, tbl[i].e_arready);
            chk({tbl[i].name, "_wr"}, wr_ot_cnt, tbl[i].e_wr);
            chk({tbl[i].name, "_rd"}, rd_ot_cnt, tbl[i].e_rd);
            chk({tbl[i].name, "_ack"}, quiesce_ack, tbl[i].e_ack);
            chk({tbl[i].name, "_err"}, err_underflow, tbl[i].e_err);
            tick();
        end

        // AW stalled downstream while a 4-beat read completes
        drive(ARV|ARR); tick();
        drive(AWV); chk("stall_awvalid", slv_AWVALID, 1); tick();
        for (int b = 0; b < 4; b++) begin
            drive(AWV | RV | ((b == 3) ? RL : IDLE));
            $display("stall beat %0d: awvalid=%0d rd=%0d", b, slv_AWVALID, rd_ot_cnt);
            chk("stall_beat_awvalid", slv_AWVALID, 1);
            chk("stall_beat_rd", rd_ot_cnt, 1);
            tick();
        end
        drive(AWV); chk("stall_after_rd", rd_ot_cnt, 0); chk("stall_after_awvalid", slv_AWVALID, 1); tick();
        drive(AWV|AWR); chk("stall_release", mst_AWREADY, 1); tick();
        drive(BV); chk("stall_wr", wr_ot_cnt, 1); tick();

        // Quiesce with 2 writes and 1 read outstanding
        drive(AWV|AWR|ARV|ARR); tick();
        drive(AWV|AWR); tick();
        drive(Q); chk("q_wr2", wr_ot_cnt, 2); chk("q_rd1", rd_ot_cnt, 1); chk("q_ack_run", quiesce_ack, 0); tick();
        drive(Q|ARV|ARR|AWV|AWR);
        chk("q_ar_blocked", mst_ARREADY, 0); chk("q_arvalid_blocked", slv_ARVALID, 0);
        chk("q_aw_blocked", mst_AWREADY, 0); tick();
        drive(Q|BV); tick();
        drive(Q|BV); chk("q_drain_ack", quiesce_ack, 0); tick();
        drive(Q|RV|RL); chk("q_last_wr", wr_ot_cnt, 0); chk("q_last_ack", quiesce_ack, 0); tick();
        drive(Q); chk("q_rd0", rd_ot_cnt, 0); chk("q_ack_not_yet", quiesce_ack, 0); tick();
        drive(Q); $display("quiesce: ack=%0d", quiesce_ack); chk("q_ack_rise", quiesce_ack, 1); tick();
        drive(Q|ARV|ARR); chk("q_quiesced_ar", mst_ARREADY, 0); chk("q_ack_hold", quiesce_ack, 1); tick();
        drive(IDLE); chk("q_ack_before_drop", quiesce_ack, 1); tick();
        drive(IDLE); chk("q_ack_drop", quiesce_ack, 0); tick();
        drive(ARV|ARR); chk("q_run_ar", mst_ARREADY, 1); tick();
        drive(RV|RL); tick();

        // Async reset in the middle of traffic with counts 5/3
        for (int i = 0; i < 3; i++) begin drive(AWV|AWR|ARV|ARR); tick(); end
        for (int i = 0; i < 2; i++) begin drive(AWV|AWR); tick(); end
        drive(AWV|RV);
        chk("pre_rst_wr", wr_ot_cnt, 5); chk("pre_rst_rd", rd_ot_cnt, 3); chk("pre_rst_err", err_underflow, 2'b01);
        #2;
        ARESETn = 1'b0;
        #1;
        $display("async reset: wr=%0d rd=%0d err=%0b ack=%0d", wr_ot_cnt, rd_ot_cnt, err_underflow, quiesce_ack);
        chk("rst_wr", wr_ot_cnt, 0); chk("rst_rd", rd_ot_cnt, 0);
        chk("rst_err", err_underflow, 0); chk("rst_ack", quiesce_ack, 0);
        tick();
        ARESETn = 1'b1;
        drive(IDLE); tick();
        chk("post_rst_wr", wr_ot_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
